// File: rtl/fp_pkg.sv
// Shared binary32 field definitions, special constants and the divider FSM state type.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [30:0] FP_PINF_MAG = 31'h7F800000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;

  // Quotient bits produced per operation (one per DIV cycle), counter runs 0..DIV_LAST.
  localparam int         Q_W      = MAN_W + 3;
  localparam logic [4:0] DIV_LAST = 5'd25;

  typedef enum logic [1:0] {IDLE, DIV, NORM} fpd_state_t;

endpackage

// File: rtl/fpd_norm_round.sv
// Combinational NORM stage: normalises the raw quotient, optionally rounds, and picks Result/flags.
// FPD_ROUND_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fpd_norm_round
  import fp_pkg::*;
(
  input  logic                   sign,
  input  logic                   a_zero,
  input  logic                   b_zero,
  input  logic [Q_W-1:0]         q,
  input  logic                   rem_nz,
  input  logic signed [9:0]      e_base,
  output logic [31:0]            result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero,
  output logic                   div_by_zero
);

`ifdef FPD_ROUND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  // Returns {carry, mantissa}; a carry means the mantissa wrapped to zero.
  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] mant,
                                               input logic g, input logic s);
    logic inc;
    inc = RND_EN & g & (s | mant[0]);
    return {1'b0, mant} + {{MAN_W{1'b0}}, inc};
  endfunction

  logic [MAN_W-1:0]   mant;
  logic               g;
  logic               s;
  logic [MAN_W:0]     rnd;
  logic signed [9:0]  e_norm;
  logic signed [9:0]  e_fin;

  always_comb begin
    if (q[Q_W-1]) begin
      mant = q[Q_W-2:2];
      g    = q[1];
      s    = q[0] | rem_nz;
    end else begin
      mant = q[Q_W-3:1];
      g    = q[0];
      s    = rem_nz;
    end
    e_norm = e_base + $signed({9'b0, q[Q_W-1]});
    rnd    = round_rne(mant, g, s);
    e_fin  = e_norm + $signed({9'b0, rnd[MAN_W]});
  end

  always_comb begin
    result      = '0;
    overflow    = 1'b0;
    underflow   = 1'b0;
    zero        = 1'b0;
    div_by_zero = 1'b0;
    if (b_zero && !a_zero) begin
      result      = {sign, FP_PINF_MAG};
      div_by_zero = 1'b1;
    end else if (b_zero) begin
      result      = FP_QNAN;
      div_by_zero = 1'b1;
    end else if (a_zero) begin
      zero = 1'b1;
    end else if (e_fin >= 10'sd255) begin
      result   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      overflow = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      result    = {sign, 31'b0};
      underflow = 1'b1;
    end else begin
      result = {sign, e_fin[EXP_W-1:0], rnd[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/fpd_seq.sv
// Sequential binary32 divider: restoring mantissa division, one quotient bit per cycle.
// Optional FPD_ROUND_EN (in fpd_norm_round) enables round-to-nearest-even.
module fpd_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic        Overflow,
  output logic        UnderFlow,
  output logic        Zero,
  output logic        DivByZero
);

  fpd_state_t          state;
  fpd_state_t          state_nxt;
  logic [4:0]          cnt;
  logic [Q_W-1:0]      rem;
  logic [Q_W-1:0]      q;
  logic [MAN_W:0]      mb;
  logic                sign;
  logic                a_zero;
  logic                b_zero;
  logic signed [9:0]   e_base;

  logic                accept;
  logic                op_zero;
  logic                rem_ge;
  logic [Q_W-1:0]      rem_diff;

  logic [31:0]         nr_result;
  logic                nr_ovf;
  logic                nr_unf;
  logic                nr_zero;
  logic                nr_dbz;

  assign accept   = (state == IDLE) && start;
  assign op_zero  = (A[30:23] == '0) || (B[30:23] == '0);
  assign rem_ge   = rem >= {2'b00, mb};
  assign rem_diff = rem - {2'b00, mb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = op_zero ? NORM : DIV;
      DIV:     if (cnt == DIV_LAST) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= (state == DIV && cnt != DIV_LAST) ? cnt + 5'd1 : '0;
  end

  // Operand latch and division datapath; unreset, only meaningful while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem    <= {2'b00, 1'b1, A[22:0]};
      q      <= '0;
      mb     <= {1'b1, B[22:0]};
      sign   <= A[31] ^ B[31];
      a_zero <= (A[30:23] == '0);
      b_zero <= (B[30:23] == '0);
      e_base <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd126;
    end else if (state == DIV) begin
      q   <= {q[Q_W-2:0], rem_ge};
      rem <= rem_ge ? {rem_diff[Q_W-2:0], 1'b0} : {rem[Q_W-2:0], 1'b0};
    end
  end

  fpd_norm_round u_norm (
    .sign        (sign),
    .a_zero      (a_zero),
    .b_zero      (b_zero),
    .q           (q),
    .rem_nz      (|rem),
    .e_base      (e_base),
    .result      (nr_result),
    .overflow    (nr_ovf),
    .underflow   (nr_unf),
    .zero        (nr_zero),
    .div_by_zero (nr_dbz)
  );

  // Output stage: registered on the NORM edge, held until the next operation completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      Result    <= '0;
      Overflow  <= 1'b0;
      UnderFlow <= 1'b0;
      Zero      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      done <= (state == NORM);
      if (state == NORM) begin
        Result    <= nr_result;
        Overflow  <= nr_ovf;
        UnderFlow <= nr_unf;
        Zero      <= nr_zero;
        DivByZero <= nr_dbz;
      end
    end
  end

endmodule
